dice_read_sequencer: RTL
========================

DICE_READ_SEQUENCER -- requirements
Module: dice_read_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_FRAMES, default 8'd4, frames to wait after roll_req before enabling detection (range 0..255).
REQ-002 SHALL have parameter MATCH_COUNT, default 3'd3, consecutive identical non-NONE results required to accept (range 1..7).
REQ-003 SHALL have parameter TIMEOUT_FRAMES, default 8'd30, capture-phase frame limit (range 1..255).
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port roll_req  input  1  one-cycle request from game FSM to read the die.
REQ-007 SHALL have port abort  input  1  one-cycle cancel of any in-progress read.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse per camera frame (VSYNC-derived).
REQ-009 SHALL have port stable_color  input  2  filtered color: 00 NONE, 01 RED, 10 GREEN, 11 BLUE.
REQ-010 SHALL have port result_ready  input  1  one-cycle pulse qualifying stable_color.
REQ-011 SHALL have port detect_enable  output  1  enables the color detector and filter.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port move_valid  output  1  result available, held until move_ack.
REQ-014 SHALL have port move_steps  output  2  RED=1, GREEN=2, BLUE=3, 0 on timeout.
REQ-015 SHALL have port move_color  output  2  accepted color, NONE on timeout.
REQ-016 SHALL have port timeout_err  output  1  qualifies move_valid as a failed read.
REQ-017 SHALL have port move_ack  input  1  consumer acknowledge of move_valid.

Function
REQ-018 SHALL implement states IDLE, SETTLE, CAPTURE, DONE, held in a registered state variable.
REQ-019 SHALL, in IDLE on roll_req, enter SETTLE next cycle with frame counter cleared; roll_req in other states SHALL be ignored.
REQ-020 SHALL, in SETTLE, count frame_start pulses starting the cycle after entry and enter CAPTURE the cycle after the count reaches SETTLE_FRAMES; SETTLE_FRAMES=0 SHALL pass to CAPTURE after one cycle.
REQ-021 SHALL drive detect_enable high only in CAPTURE, registered (asserts the cycle CAPTURE is entered).
REQ-022 SHALL, in CAPTURE on result_ready: NONE clears the match counter; a non-NONE color equal to the last color increments it; a different non-NONE color loads it as last color with count 1.
REQ-023 SHALL enter DONE with move_color=last color, move_steps mapped, timeout_err=0 the cycle after the match counter reaches MATCH_COUNT.
REQ-024 SHALL count frame_start in CAPTURE and on reaching TIMEOUT_FRAMES enter DONE with move_color=NONE, move_steps=0, timeout_err=1.
REQ-025 SHALL give a completing match priority over a same-cycle timeout.
REQ-026 SHALL hold move_valid and result outputs stable in DONE until move_ack, then return to IDLE next cycle with move_valid low; move_ack outside DONE is ignored.
REQ-027 SHALL return to IDLE next cycle on abort from any state, clearing move_valid, timeout_err, detect_enable and counters; abort beats roll_req and move_ack in the same cycle.
REQ-028 SHALL use 8-bit saturating frame counters and a 3-bit match counter; no wrap-around.

Reset
REQ-029 SHALL, on reset, asynchronously force IDLE, detect_enable=0, busy=0, move_valid=0, move_steps=0, move_color=NONE, timeout_err=0, all counters and last color to 0, including mid-operation.

Configuration
REQ-030 SHALL, with DICE_SEQ_TIMEOUT_EN defined, implement REQ-024/REQ-025; without it, SHALL omit the capture frame counter, remain in CAPTURE until a match or abort, and tie timeout_err to 0.

Structure
REQ-031 SHALL take color codes, the state typedef and the color-to-steps mapping function from shared package dice_pkg.
REQ-032 SHALL place the REQ-022 logic in sub-module color_match_counter (inputs: clear, result_ready, stable_color; outputs: last_color, match_hit).

Verification
REQ-033 SHALL cover: roll_req, 4 frame_start, 3 result_ready RED -> detect_enable after 4th frame, move_valid with steps=1, color=01, hold until move_ack, IDLE next cycle.
REQ-034 SHALL cover: sequence GREEN, BLUE, BLUE, NONE, BLUE, BLUE, BLUE -> DONE only after final BLUE, steps=3.
REQ-035 SHALL cover (macro defined): 30 frame_start in CAPTURE with only NONE results -> move_valid=1, timeout_err=1, steps=0; 30th frame coincident with 3rd GREEN -> steps=2, timeout_err=0.
REQ-036 SHALL cover: abort in SETTLE, CAPTURE and DONE, plus abort with roll_req same cycle in IDLE -> IDLE next cycle, all outputs cleared, no new read.
REQ-037 SHALL cover: reset asserted mid-CAPTURE with match count 2 -> all outputs at reset values immediately; after release, one RED result does not complete a read.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared color codes, sequencer state type and color-to-steps mapping for the
// dice read sequencer.
package dice_pkg;

  typedef enum logic [1:0] {
    COLOR_NONE  = 2'b00,
    COLOR_RED   = 2'b01,
    COLOR_GREEN = 2'b10,
    COLOR_BLUE  = 2'b11
  } color_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam logic [7:0] FRAME_CNT_MAX = 8'hFF;
  localparam logic [2:0] MATCH_CNT_MAX = 3'h7;

  function automatic logic [1:0] color_to_steps(input color_e c);
    case (c)
      COLOR_RED:   return 2'd1;
      COLOR_GREEN: return 2'd2;
      COLOR_BLUE:  return 2'd3;
      default:     return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/color_match_counter.sv
// Tracks the last non-NONE color reported by the filter and how many qualified
// results in a row have repeated it; match_hit once the run reaches MATCH_COUNT.
module color_match_counter
  import dice_pkg::*;
#(
  parameter logic [2:0] MATCH_COUNT = 3'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       result_ready,
  input  logic [1:0] stable_color,
  output logic [1:0] last_color,
  output logic       match_hit
);

  color_e     last_q, last_d;
  logic [2:0] cnt_q, cnt_d;
  color_e     in_color;

  assign in_color = color_e'(stable_color);

  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (clear) begin
      last_d = COLOR_NONE;
      cnt_d  = '0;
    end else if (result_ready) begin
      if (in_color == COLOR_NONE) begin
        cnt_d = '0;
      end else if (in_color == last_q) begin
        if (cnt_q != MATCH_CNT_MAX) cnt_d = cnt_q + 3'd1;
      end else begin
        last_d = in_color;
        cnt_d  = 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= COLOR_NONE;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last_color = last_q;
  assign match_hit  = (cnt_q >= MATCH_COUNT);

endmodule

// File: rtl/dice_read_sequencer.sv
// Sequences one die read: settle for a few frames, capture until the filter
// agrees on a color, then hold the move until acknowledged. Define
// DICE_SEQ_TIMEOUT_EN to bound the capture phase by TIMEOUT_FRAMES frames.
module dice_read_sequencer
  import dice_pkg::*;
#(
  parameter logic [7:0] SETTLE_FRAMES  = 8'd4,
  parameter logic [2:0] MATCH_COUNT    = 3'd3,
  parameter logic [7:0] TIMEOUT_FRAMES = 8'd30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_req,
  input  logic       abort,
  input  logic       frame_start,
  input  logic [1:0] stable_color,
  input  logic       result_ready,
  output logic       detect_enable,
  output logic       busy,
  output logic       move_valid,
  output logic [1:0] move_steps,
  output logic [1:0] move_color,
  output logic       timeout_err,
  input  logic       move_ack
);

  state_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       detect_en_q, detect_en_d;
  logic       busy_q, busy_d;
  logic       move_valid_q, move_valid_d;
  logic [1:0] move_steps_q, move_steps_d;
  color_e     move_color_q, move_color_d;
  logic       timeout_err_q, timeout_err_d;

  logic       mc_clear;
  logic [1:0] last_color;
  logic       match_hit;

  // Match history only lives while capturing; any other state wipes it.
  assign mc_clear = abort || (state_q != ST_CAPTURE);

  color_match_counter #(
    .MATCH_COUNT(MATCH_COUNT)
  ) u_match (
    .clk          (clk),
    .reset        (reset),
    .clear        (mc_clear),
    .result_ready (result_ready),
    .stable_color (stable_color),
    .last_color   (last_color),
    .match_hit    (match_hit)
  );

`ifndef DICE_SEQ_TIMEOUT_EN
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_FRAMES;
`endif

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    detect_en_d   = detect_en_q;
    move_valid_d  = move_valid_q;
    move_steps_d  = move_steps_q;
    move_color_d  = move_color_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (roll_req) begin
          state_d     = ST_SETTLE;
          frame_cnt_d = '0;
        end
      end
      ST_SETTLE: begin
        if (frame_cnt_q >= SETTLE_FRAMES) begin
          state_d     = ST_CAPTURE;
          frame_cnt_d = '0;
          detect_en_d = 1'b1;
        end else if (frame_start && frame_cnt_q != FRAME_CNT_MAX) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      ST_CAPTURE: begin
        // A completed match is checked first so it wins over a same-cycle timeout.
        if (match_hit) begin
          state_d       = ST_DONE;
          detect_en_d   = 1'b0;
          move_valid_d  = 1'b1;
          move_color_d  = color_e'(last_color);
          move_steps_d  = color_to_steps(color_e'(last_color));
          timeout_err_d = 1'b0;
        end
`ifdef DICE_SEQ_TIMEOUT_EN
        else if (frame_cnt_q >= TIMEOUT_FRAMES) begin
          state_d       = ST_DONE;
          detect_en_d   = 1'b0;
          move_valid_d  = 1'b1;
          move_color_d  = COLOR_NONE;
          move_steps_d  = 2'd0;
          timeout_err_d = 1'b1;
        end else if (frame_start && frame_cnt_q != FRAME_CNT_MAX) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
`endif
      end
      ST_DONE: begin
        if (move_ack) begin
          state_d       = ST_IDLE;
          move_valid_d  = 1'b0;
          move_steps_d  = 2'd0;
          move_color_d  = COLOR_NONE;
          timeout_err_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d       = ST_IDLE;
      frame_cnt_d   = '0;
      detect_en_d   = 1'b0;
      move_valid_d  = 1'b0;
      move_steps_d  = 2'd0;
      move_color_d  = COLOR_NONE;
      timeout_err_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      frame_cnt_q   <= '0;
      detect_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      move_valid_q  <= 1'b0;
      move_steps_q  <= 2'd0;
      move_color_q  <= COLOR_NONE;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      detect_en_q   <= detect_en_d;
      busy_q        <= busy_d;
      move_valid_q  <= move_valid_d;
      move_steps_q  <= move_steps_d;
      move_color_q  <= move_color_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign detect_enable = detect_en_q;
  assign busy          = busy_q;
  assign move_valid    = move_valid_q;
  assign move_steps    = move_steps_q;
  assign move_color    = move_color_q;
  assign timeout_err   = timeout_err_q;

endmodule
